// File: rtl/address_generator_pkg.sv
// address_generator_pkg
//   Shared definitions for the address generator and the ALU that consumes
//   its flags: state encoding, parameter defaults and the per-term flag
//   convention.
package address_generator_pkg;

    typedef enum logic [1:0] {
        AG_IDLE  = 2'd0,
        AG_PRIME = 2'd1,
        AG_RUN   = 2'd2,
        AG_DONE  = 2'd3
    } ag_state_t;

    localparam int AG_N_INPUTS_DEF  = 4;
    localparam int AG_N_NEURONS_DEF = 4;
    localparam int AG_ADDR_W_DEF    = 8;

    // Per-term flags as the ALU sees them:
    //   term_valid : the presented product term is consumed this cycle
    //   acc_first  : load the product instead of accumulating (neuron start)
    //   acc_last   : final product of the neuron; the sum is complete after it
    typedef struct packed {
        logic term_valid;
        logic acc_first;
        logic acc_last;
    } alu_flags_t;

    // acc_first/acc_last follow the RUN state only, so the ALU still sees
    // the neuron boundary while a term is held by stall.
    function automatic alu_flags_t decode_flags(input logic in_run,
                                                input logic stall,
                                                input logic first,
                                                input logic last);
        alu_flags_t f;
        f.term_valid = in_run & ~stall;
        f.acc_first  = in_run & first;
        f.acc_last   = in_run & last;
        return f;
    endfunction

endpackage

// File: rtl/address_generator_if.sv
// address_generator_if
//   Control strobes in, addresses and ALU flags out.
//   master : control-unit / test side (drives AG_rst, AG_read, stall)
//   slave  : address generator side (drives addresses and flags)
interface address_generator_if
    import address_generator_pkg::*;
#(
    parameter int ADDR_W = AG_ADDR_W_DEF
);
    logic              AG_rst;
    logic              AG_read;
    logic              stall;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] neuron_idx;
    logic              mem_rd;
    logic              term_valid;
    logic              acc_first;
    logic              acc_last;
    logic              layer_done;

    modport master (
        output AG_rst, AG_read, stall,
        input  w_addr, x_addr, neuron_idx, mem_rd,
               term_valid, acc_first, acc_last, layer_done
    );

    modport slave (
        input  AG_rst, AG_read, stall,
        output w_addr, x_addr, neuron_idx, mem_rd,
               term_valid, acc_first, acc_last, layer_done
    );
endinterface

// File: rtl/address_generator_mod_counter.sv
// mod_counter
//   Modulus counter: counts 0..MODULUS-1 and wraps to 0.
//   clk, reset (async, active-low), en (advance), clr (sync clear, wins over en)
//   count : current value
//   tc    : terminal count, high while count == MODULUS-1
module mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign tc = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/address_generator.sv
// address_generator
//   Sequences weight-memory and input-buffer addresses for one
//   fully-connected layer, inputs inner / neurons outer, and emits the ALU
//   flags for each product term.
//   clk   : clock
//   reset : asynchronous active-low reset
//   ag    : slave side of address_generator_if
//           in  AG_rst (sync clear), AG_read (prime), stall (hold term)
//           out w_addr, x_addr, neuron_idx, mem_rd, term_valid,
//               acc_first, acc_last, layer_done
module address_generator
    import address_generator_pkg::*;
#(
    parameter int N_INPUTS  = AG_N_INPUTS_DEF,
    parameter int N_NEURONS = AG_N_NEURONS_DEF,
    parameter int ADDR_W    = AG_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    address_generator_if.slave  ag
);
    ag_state_t         state;
    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W-1:0] x_cnt;
    logic [ADDR_W-1:0] n_cnt;
    logic              x_tc;
    logic              n_tc;
    logic              strobe_clr;
    logic              in_run;
    logic              last_term;
    logic              advance;
    alu_flags_t        flags;

    assign strobe_clr = ag.AG_rst | ag.AG_read;
    assign in_run     = (state == AG_RUN);
    assign last_term  = x_tc & n_tc;
    // The final term is consumed without moving the counters, so DONE keeps
    // showing the last addresses.
    assign advance    = in_run & ~ag.stall & ~last_term & ~strobe_clr;

    mod_counter #(.WIDTH(ADDR_W), .MODULUS(N_INPUTS)) u_x_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .clr   (strobe_clr),
        .count (x_cnt),
        .tc    (x_tc)
    );

    mod_counter #(.WIDTH(ADDR_W), .MODULUS(N_NEURONS)) u_n_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance & x_tc),
        .clr   (strobe_clr),
        .count (n_cnt),
        .tc    (n_tc)
    );

    // w_addr runs alongside the counters instead of neuron_idx*N_INPUTS+x_addr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= AG_IDLE;
            w_addr_q <= '0;
        end else if (ag.AG_rst) begin
            state    <= AG_IDLE;
            w_addr_q <= '0;
        end else if (ag.AG_read) begin
            state    <= AG_PRIME;
            w_addr_q <= '0;
        end else begin
            case (state)
                AG_IDLE:  state <= AG_RUN;
                AG_PRIME: state <= AG_RUN;
                AG_RUN: begin
                    if (!ag.stall) begin
                        if (last_term) state <= AG_DONE;
                        else           w_addr_q <= w_addr_q + ADDR_W'(1);
                    end
                end
                default:  state <= AG_DONE;
            endcase
        end
    end

    // NOTE: every output of this block is assigned a default first so no
    // path through it leaves a value held, which would infer a latch.
    always_comb begin
        flags         = '0;
        ag.mem_rd     = 1'b0;
        ag.layer_done = 1'b0;
        case (state)
            AG_PRIME: ag.mem_rd = 1'b1;
            AG_RUN: begin
                ag.mem_rd = 1'b1;
                flags     = decode_flags(1'b1, ag.stall, (x_cnt == '0), x_tc);
            end
            AG_DONE:  ag.layer_done = 1'b1;
            default:  ;
        endcase
    end

    assign ag.term_valid = flags.term_valid;
    assign ag.acc_first  = flags.acc_first;
    assign ag.acc_last   = flags.acc_last;
    assign ag.w_addr     = w_addr_q;
    assign ag.x_addr     = x_cnt;
    assign ag.neuron_idx = n_cnt;
endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator
//   Scoreboard bench: each cycle the expected outputs are computed from a
//   term-index model and queued when stimulus is driven, then popped and
//   compared against the DUT on the falling edge. Instance a uses the
//   default 4x4 layer, instance b a 1-input x 3-neuron layer.
module tb_address_generator;
    import address_generator_pkg::*;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] x;
        logic [7:0] n;
        logic       mem_rd;
        logic       tv;
        logic       af;
        logic       al;
        logic       ld;
    } out_t;

    typedef struct {
        ag_state_t st;
        int        t;
    } model_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    address_generator_if #(.ADDR_W(8)) ag_a ();
    address_generator_if #(.ADDR_W(8)) ag_b ();

    address_generator #(.N_INPUTS(4), .N_NEURONS(4), .ADDR_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .ag    (ag_a)
    );

    address_generator #(.N_INPUTS(1), .N_NEURONS(3), .ADDR_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .ag    (ag_b)
    );

    int     total = 0;
    int     bad   = 0;
    out_t   sb[$];
    model_t ma;
    model_t mb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected outputs from the term index t: w = t, x = t mod N_INPUTS,
    // neuron = t div N_INPUTS.
    function automatic out_t exp_out(model_t m, logic st, int ni);
        out_t o;
        o = '0;
        if (m.st != AG_IDLE) begin
            o.w = 8'(m.t);
            o.x = 8'(m.t % ni);
            o.n = 8'(m.t / ni);
        end
        case (m.st)
            AG_PRIME: o.mem_rd = 1'b1;
            AG_RUN: begin
                o.mem_rd = 1'b1;
                o.tv     = ~st;
                o.af     = ((m.t % ni) == 0);
                o.al     = ((m.t % ni) == ni - 1);
            end
            AG_DONE:  o.ld = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

    function automatic model_t next_m(model_t m, logic rn, logic r, logic rd, logic st,
                                      int ni, int nn);
        model_t q;
        q = m;
        if (!rn) begin
            q.st = AG_IDLE; q.t = 0;
        end else if (r) begin
            q.st = AG_IDLE; q.t = 0;
        end else if (rd) begin
            q.st = AG_PRIME; q.t = 0;
        end else begin
            case (m.st)
                AG_IDLE, AG_PRIME: q.st = AG_RUN;
                AG_RUN: begin
                    if (!st) begin
                        if (m.t == ni * nn - 1) q.st = AG_DONE;
                        else                    q.t  = m.t + 1;
                    end
                end
                default: ;
            endcase
        end
        return q;
    endfunction

    function automatic out_t sample_a();
        return {ag_a.w_addr, ag_a.x_addr, ag_a.neuron_idx, ag_a.mem_rd,
                ag_a.term_valid, ag_a.acc_first, ag_a.acc_last, ag_a.layer_done};
    endfunction

    function automatic out_t sample_b();
        return {ag_b.w_addr, ag_b.x_addr, ag_b.neuron_idx, ag_b.mem_rd,
                ag_b.term_valid, ag_b.acc_first, ag_b.acc_last, ag_b.layer_done};
    endfunction

    // Entered just after a rising edge: drive, queue expectation, compare on
    // the falling edge, then step both models across the next rising edge.
    task automatic cycle(input bit sel, input string tag, input logic r, input logic rd,
                         input logic st, output out_t act);
        if (!sel) begin
            ag_a.AG_rst = r; ag_a.AG_read = rd; ag_a.stall = st;
            sb.push_back(exp_out(ma, st, 4));
        end else begin
            ag_b.AG_rst = r; ag_b.AG_read = rd; ag_b.stall = st;
            sb.push_back(exp_out(mb, st, 1));
        end
        @(negedge clk);
        act = sel ? sample_b() : sample_a();
        check(tag, act, sb.pop_front());
        @(posedge clk);
        if (!sel) begin
            ma = next_m(ma, reset, r, rd, st, 4, 4);
            mb = next_m(mb, reset, ag_b.AG_rst, ag_b.AG_read, ag_b.stall, 1, 3);
        end else begin
            mb = next_m(mb, reset, r, rd, st, 1, 3);
            ma = next_m(ma, reset, ag_a.AG_rst, ag_a.AG_read, ag_a.stall, 4, 4);
        end
        #1;
    endtask

    task automatic run_to(input string tag, input int target);
        out_t act;
        int   n;
        n = 0;
        while (!(ma.st == AG_RUN && ma.t == target) && n < 40) begin
            cycle(1'b0, tag, 1'b0, 1'b0, 1'b0, act);
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t act;
        int   runs;
        int   stall_left;
        logic st;

        reset = 1'b0;
        ag_a.AG_rst = 1'b0; ag_a.AG_read = 1'b0; ag_a.stall = 1'b0;
        ag_b.AG_rst = 1'b0; ag_b.AG_read = 1'b0; ag_b.stall = 1'b0;
        ma = '{AG_IDLE, 0};
        mb = '{AG_IDLE, 0};
        @(posedge clk); #1;

        // Normal layer: reset, AG_rst x2, AG_read x1, then run to DONE.
        cycle(1'b0, "reset_state", 1'b0, 1'b0, 1'b0, act);
        reset = 1'b1;
        cycle(1'b0, "ag_rst", 1'b1, 1'b0, 1'b0, act);
        cycle(1'b0, "ag_rst", 1'b1, 1'b0, 1'b0, act);
        cycle(1'b0, "ag_read", 1'b0, 1'b1, 1'b0, act);
        for (int i = 0; i < 20; i++) cycle(1'b0, "layer", 1'b0, 1'b0, 1'b0, act);

        // Stall three cycles on w_addr 5; DONE follows 19 RUN cycles.
        cycle(1'b0, "stall_read", 1'b0, 1'b1, 1'b0, act);
        cycle(1'b0, "stall_prime", 1'b0, 1'b0, 1'b0, act);
        runs = 0;
        stall_left = 3;
        for (int i = 0; i < 40; i++) begin
            st = (ma.st == AG_RUN && ma.t == 5 && stall_left > 0);
            if (st) stall_left--;
            cycle(1'b0, "stall", 1'b0, 1'b0, st, act);
            if (act.ld) break;
            runs++;
        end
        check("stall_done_latency", 32'(runs), 32'd19);

        // AG_rst mid-run, then both strobes together.
        cycle(1'b0, "rst_read", 1'b0, 1'b1, 1'b0, act);
        run_to("rst_run", 9);
        cycle(1'b0, "rst_at_9", 1'b1, 1'b0, 1'b0, act);
        cycle(1'b0, "rst_both", 1'b1, 1'b1, 1'b0, act);
        cycle(1'b0, "rst_both_idle", 1'b0, 1'b0, 1'b0, act);
        cycle(1'b0, "rst_restart", 1'b0, 1'b0, 1'b0, act);

        // AG_read in RUN at w_addr 6, then again while DONE.
        run_to("read_run", 6);
        cycle(1'b0, "read_at_6", 1'b0, 1'b1, 1'b0, act);
        cycle(1'b0, "read_prime", 1'b0, 1'b0, 1'b0, act);
        for (int i = 0; i < 18; i++) cycle(1'b0, "read_rerun", 1'b0, 1'b0, 1'b0, act);
        cycle(1'b0, "read_in_done", 1'b0, 1'b1, 1'b0, act);
        cycle(1'b0, "read_done_prime", 1'b0, 1'b0, 1'b0, act);
        for (int i = 0; i < 3; i++) cycle(1'b0, "read_done_rerun", 1'b0, 1'b0, 1'b0, act);

        // Asynchronous reset between edges while in RUN.
        #2 reset = 1'b0;
        #1;
        sb.push_back('0);
        act = sample_a();
        check("async_reset", act, sb.pop_front());
        ma = '{AG_IDLE, 0};
        mb = '{AG_IDLE, 0};
        @(posedge clk); #1;
        cycle(1'b0, "async_hold", 1'b0, 1'b0, 1'b0, act);
        reset = 1'b1;
        cycle(1'b0, "async_release", 1'b0, 1'b0, 1'b0, act);
        cycle(1'b0, "async_run", 1'b0, 1'b0, 1'b0, act);

        // One input per neuron, three neurons.
        cycle(1'b1, "small_rst", 1'b1, 1'b0, 1'b0, act);
        cycle(1'b1, "small_read", 1'b0, 1'b1, 1'b0, act);
        for (int i = 0; i < 6; i++) cycle(1'b1, "small", 1'b0, 1'b0, 1'b0, act);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/address_generator.md
# address_generator

Responder to the control unit's `AG_rst` / `AG_read` strobes. It sequences the weight-memory and input-buffer addresses for one fully-connected layer, iterating over inputs within each neuron. It emits per-term flags (`term_valid`, `acc_first`, `acc_last`) that the ALU uses to load or accumulate, and asserts `layer_done` after the last term. It sits between the control unit and the weight/input memories, and is the consumer end of the reset/prime/run sequence the control unit issues.

## Interface
- `N_INPUTS`, default 4, inputs per neuron (>= 1).
- `N_NEURONS`, default 4, neurons per layer (>= 1).
- `ADDR_W`, default 8, address width; must satisfy 2^ADDR_W >= N_INPUTS*N_NEURONS.
- `clk`  in  1  clock; one clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `AG_rst`  in  1  synchronous clear from control unit, active-high.
- `AG_read`  in  1  prime request from control unit, active-high.
- `stall`  in  1  downstream not ready; holds the current term.
- `w_addr`  out  ADDR_W  weight address, equal to neuron_idx*N_INPUTS + x_addr.
- `x_addr`  out  ADDR_W  input-buffer index, 0..N_INPUTS-1.
- `neuron_idx`  out  ADDR_W  current neuron, 0..N_NEURONS-1.
- `mem_rd`  out  1  memory read enable.
- `term_valid`  out  1  current address is a product term to be consumed.
- `acc_first`  out  1  first term of a neuron; the ALU loads instead of accumulating.
- `acc_last`  out  1  last term of a neuron.
- `layer_done`  out  1  all terms issued; level signal.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- Reset low: state IDLE, all counters 0, every output 0, applied immediately.
- Priority at each edge, highest first:
  - `AG_rst` = 1: go to IDLE, clear counters. This wins over `AG_read`.
  - `AG_read` = 1 in any state: go to PRIME, clear counters.
  - Otherwise the state transitions below apply.
- IDLE: all outputs 0. If both strobes are low, go to RUN.
- PRIME:
  - Counters held at 0; `mem_rd` = 1 (prefetch of address 0).
  - `term_valid`, `acc_first`, `acc_last` = 0.
  - Go to RUN when `AG_read` = 0.
- RUN:
  - `mem_rd` = 1 and `term_valid` = ~`stall`.
  - On each non-stalled cycle, the term is consumed and counters advance.
  - `x_addr` wraps at N_INPUTS-1 to 0, incrementing `neuron_idx`.
  - `w_addr` is a running counter (+1 per term); no multiplier.
  - `acc_first` = (x_addr == 0). `acc_last` = (x_addr == N_INPUTS-1). Both are gated by RUN only, not by `stall`.
  - When the consumed term is the last of the last neuron, go to DONE; counters are not advanced past it.
- DONE:
  - `layer_done` = 1; `mem_rd`, `term_valid`, `acc_*` = 0.
  - Addresses hold their last values.
  - Remain in DONE until `AG_rst` or `AG_read`.
- `stall` is ignored outside RUN.
- With N_INPUTS = 1, `acc_first` and `acc_last` are both high on every RUN term.

## Timing
- Addresses and state are registers. Flags are decoded only from state and counter registers.
- `term_valid` = RUN & ~`stall` is the sole input-to-output combinational path.
- Strobe-to-effect latency is one edge: `AG_rst` or `AG_read` sampled at edge k is reflected in the outputs after edge k.
- The RUN cycle that presents term t is the (t+1)-th non-stalled RUN cycle.
- A full layer takes N_INPUTS*N_NEURONS non-stalled RUN cycles plus the stalled cycles. `layer_done` rises the edge after the last term is consumed.
- Memory read latency is not compensated here; the ALU delays the flags to match the memory latency.
- A canonical control-unit sequence is compatible:
  - `AG_rst`=1 → IDLE.
  - (0,1) for one cycle → PRIME.
  - (0,0) → RUN.

## Structure
- Shared package holds:
  - State encoding: AG_IDLE=2'd0, AG_PRIME=2'd1, AG_RUN=2'd2, AG_DONE=2'd3.
  - Default values for N_INPUTS, N_NEURONS, ADDR_W.
  - The ALU flag conventions, so the ALU and this block agree.
- One sub-module: `mod_counter`, a parameterised modulus counter with enable, clear, and terminal-count output. It is instantiated for `x_addr` (modulus N_INPUTS) and for `neuron_idx` (modulus N_NEURONS).

## Test plan
- Normal layer, default params:
  - Stimulus: reset low 2 cycles; `AG_rst`=1 for 2 cycles; `AG_read`=1 for 1 cycle; then both 0.
  - PRIME for 1 cycle: `mem_rd`=1, `w_addr`=0, `term_valid`=0.
  - Then 16 RUN cycles: `w_addr` 0..15; `x_addr` 0,1,2,3 repeating; `neuron_idx` 0..3.
  - `acc_first` at `w_addr` 0, 4, 8, 12; `acc_last` at 3, 7, 11, 15.
  - Then `layer_done`=1 and `mem_rd`=0, held.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles while `w_addr`=5.
  - `w_addr` holds 5 with `term_valid`=0 and `mem_rd`=1.
  - `layer_done` rises 19 RUN cycles after entry.
- `AG_rst` mid-run:
  - Stimulus: `AG_rst`=1 at `w_addr`=9 → IDLE next cycle, all outputs 0.
  - Stimulus: `AG_rst` and `AG_read` both high → IDLE, not PRIME.
- `AG_read` restart:
  - Stimulus: `AG_read` pulse in RUN at `w_addr`=6.
  - Expected: PRIME with counters at 0, then RUN restarts at `w_addr`=0.
  - Same pulse while in DONE: `layer_done` drops and the sequence restarts.
- Asynchronous reset: `reset` driven low between edges during RUN → outputs 0 immediately, with no clock edge.
- Small configuration:
  - Params: N_INPUTS=1, N_NEURONS=3.
  - Expected: 3 terms, `w_addr` 0, 1, 2, with `acc_first`=`acc_last`=1 each; then `layer_done`=1.
